or_gate_mux2: RTL and testbench

Bitwise two-input OR built only from 2:1 multiplexer cells, with the mux select driven by input A. It is a gate-from-mux building block in the combinational-primitives library. It also provides a registered copy of the result with a valid flag so that clocked datapaths can consume it directly. The combinational output behaves exactly as a plain OR gate. The registered output adds one cycle of latency.

---
 rtl/or_gate_mux2_pkg.sv | 21 ++
 rtl/or_gate_mux2_mux2.sv | 22 ++
 rtl/or_gate_mux2.sv | 98 +++++++++
 tb/tb_or_gate_mux2.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/or_gate_mux2_pkg.sv
// ----------------------------------------------------------------------------
// or_gate_mux2_pkg
//
// Shared constants for the gate-from-mux OR primitive.
//   MUX_TIE_HIGH   : constant tied onto the d1 leg of every lane mux; with the
//                    operand A bit on the select this turns the mux into OR.
//   WIDTH_MIN/MAX  : legal lane-count range accepted by or_gate_mux2.
//   width_is_legal : helper used by the elaboration-time WIDTH check.
// ----------------------------------------------------------------------------
package or_gate_mux2_pkg;

    localparam logic MUX_TIE_HIGH = 1'b1;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    function automatic bit width_is_legal(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage : or_gate_mux2_pkg

// File: rtl/or_gate_mux2_mux2.sv
// ----------------------------------------------------------------------------
// mux2
//
// Single-bit 2:1 multiplexer cell, the only logic element used to build the
// OR lanes of or_gate_mux2.
//
// Ports:
//   sel : select; 0 passes d0, 1 passes d1
//   d0  : data input chosen when sel = 0
//   d1  : data input chosen when sel = 1
//   y   : mux output
// ----------------------------------------------------------------------------
module mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule : mux2

// File: rtl/or_gate_mux2.sv
// ----------------------------------------------------------------------------
// or_gate_mux2
//
// Bitwise two-input OR built purely from 2:1 mux cells. Lane i uses A[i] as
// the mux select, B[i] on d0 and a constant 1 on d1, so the lane output is
// A[i] ? 1 : B[i], which is exactly A[i] | B[i]. A registered copy of the
// result with a valid flag is provided for clocked datapaths.
//
// Parameters:
//   WIDTH     : number of independent OR lanes (1..64)
//
// Ports:
//   clk       : rising-edge clock, registered path only
//   rst       : synchronous active-high reset of the registered path
//   A         : operand A, bit i selects lane i's mux
//   B         : operand B, bit i is lane i's d0 input
//   in_valid  : qualifies A/B for capture into Y_q
//   Y         : combinational result, equals A | B
//   Y_q       : registered result, updated on edges where in_valid = 1
//   out_valid : high for one cycle after each valid capture
// ----------------------------------------------------------------------------
module or_gate_mux2
    import or_gate_mux2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             out_valid
);

    // ------------------------------------------------------------------------
    // Elaboration-time legality check on the lane count.
    // ------------------------------------------------------------------------
    generate
        if (!width_is_legal(WIDTH)) begin : g_bad_width
            $error("or_gate_mux2: WIDTH=%0d outside legal range %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Combinational lanes: one mux per bit, no cross-lane logic. The OR comes
    // entirely from wiring the tie-high constant onto the d1 leg.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] lane_y;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            mux2 u_mux2 (
                .sel (A[gi]),
                .d0  (B[gi]),
                .d1  (MUX_TIE_HIGH),
                .y   (lane_y[gi])
            );
        end
    endgenerate

    assign Y = lane_y;

    // ------------------------------------------------------------------------
    // Registered path. Reset dominates in_valid; without a valid input the
    // data register holds while the valid flag drops, so Y_q always shows
    // the most recent accepted result.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] y_q_reg;
    logic [WIDTH-1:0] y_q_next;
    logic             out_valid_reg;
    logic             out_valid_next;

    always_comb begin
        y_q_next       = y_q_reg;
        out_valid_next = 1'b0;
        if (in_valid) begin
            y_q_next       = lane_y;
            out_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            y_q_reg       <= y_q_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign Y_q       = y_q_reg;
    assign out_valid = out_valid_reg;

endmodule : or_gate_mux2

// File: tb/tb_or_gate_mux2.sv
// ----------------------------------------------------------------------------
// tb_or_gate_mux2
//
// Drives three or_gate_mux2 instances (WIDTH = 1, 4, 8) from one shared 8-bit
// stimulus (narrow instances see the low bits). Inputs change on the falling
// edge; Y is checked 10 ns later, and the registered outputs are checked 1 ns
// after the following rising edge against a scoreboard queue filled when the
// stimulus was driven.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_or_gate_mux2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a_drv;
    logic [7:0] b_drv;

    logic [0:0] y_w1,  y_q_w1;
    logic [3:0] y_w4,  y_q_w4;
    logic [7:0] y_w8,  y_q_w8;
    logic       ov_w1, ov_w4, ov_w8;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    typedef struct packed {
        logic [7:0] y_q;
        logic       out_valid;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_y_q;

    or_gate_mux2 #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .A         (a_drv[0:0]),
        .B         (b_drv[0:0]),
        .in_valid  (in_valid),
        .Y         (y_w1),
        .Y_q       (y_q_w1),
        .out_valid (ov_w1)
    );

    or_gate_mux2 #(.WIDTH(4)) u_dut_w4 (
        .clk       (clk),
        .rst       (rst),
        .A         (a_drv[3:0]),
        .B         (b_drv[3:0]),
        .in_valid  (in_valid),
        .Y         (y_w4),
        .Y_q       (y_q_w4),
        .out_valid (ov_w4)
    );

    or_gate_mux2 #(.WIDTH(8)) u_dut_w8 (
        .clk       (clk),
        .rst       (rst),
        .A         (a_drv),
        .B         (b_drv),
        .in_valid  (in_valid),
        .Y         (y_w8),
        .Y_q       (y_q_w8),
        .out_valid (ov_w8)
    );

    // 40 ns period: the 10 ns combinational sample after a falling-edge
    // stimulus change lands well clear of the rising edge.
    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One transaction: drive on the falling edge, check Y after 10 ns, then
    // check the registered outputs just after the next rising edge.
    task automatic step(input logic r, input logic v,
                        input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        exp_t got;
        logic [7:0] or_ref;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a_drv    = a;
        b_drv    = b;
        or_ref   = a | b;
        if (r)      model_y_q = 8'h00;
        else if (v) model_y_q = or_ref;
        e.y_q       = model_y_q;
        e.out_valid = !r && v;
        sb_q.push_back(e);
        #10;
        check("y_w1", 64'(y_w1), 64'(or_ref[0]));
        check("y_w4", 64'(y_w4), 64'(or_ref[3:0]));
        check("y_w8", 64'(y_w8), 64'(or_ref));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(0), 64'(1));
        end else begin
            got = sb_q.pop_front();
            check("y_q_w1", 64'(y_q_w1), 64'(got.y_q[0]));
            check("y_q_w4", 64'(y_q_w4), 64'(got.y_q[3:0]));
            check("y_q_w8", 64'(y_q_w8), 64'(got.y_q));
            check("ov_w1",  64'(ov_w1),  64'(got.out_valid));
            check("ov_w4",  64'(ov_w4),  64'(got.out_valid));
            check("ov_w8",  64'(ov_w8),  64'(got.out_valid));
        end
        txn++;
        $display("txn %0d rst=%0b vld=%0b a=%02h b=%02h y8=%02h yq8=%02h ov=%0b",
                 txn, r, v, a, b, y_w8, y_q_w8, ov_w8);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a_drv     = 8'h00;
        b_drv     = 8'h00;
        model_y_q = 8'h00;

        // Reset held for two cycles.
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00);

        // WIDTH=1 truth table (register path idle).
        step(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h01);
        step(1'b0, 1'b0, 8'h01, 8'h00);
        step(1'b0, 1'b0, 8'h01, 8'h01);

        // Single valid capture then an idle cycle that must hold Y_q.
        step(1'b0, 1'b1, 8'h01, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset priority over in_valid with A=B=1.
        step(1'b1, 1'b1, 8'hFF, 8'hFF);

        // Streaming with a one-cycle reset pulse in the middle.
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);

        // Eight-lane pattern.
        step(1'b0, 1'b1, 8'hA5, 8'h0F);
        step(1'b0, 1'b0, 8'h5A, 8'h00);

        // Exhaustive four-lane sweep, back-to-back valid.
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, {4'h0, 4'(i >> 4)}, {4'h0, 4'(i)});
        end

        // A few random eight-lane transactions with mixed valid.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_or_gate_mux2
